// File: rtl/risc16_pkg.sv
// Shared RiSC-16 definitions: datapath widths, reset vector, opcodes and the
// fetch-to-decode entry layout.
package risc16_pkg;

  localparam int ADDR_W = 16;
  localparam int INST_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/risc16_sync_fifo.sv
// Single-clock FIFO with synchronous flush; push while full is accepted only
// when a pop frees a slot in the same cycle.
module risc16_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/risc16_fetch_unit.sv
// RiSC-16 fetch stage: credit-limited requests to instruction memory, a prefetch
// queue toward decode, and flush/discard handling for redirects and reset.
module risc16_fetch_unit #(
  parameter int                ADDR_W      = risc16_pkg::ADDR_W,
  parameter int                INST_W      = risc16_pkg::INST_W,
  parameter int                QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = risc16_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 2;
  localparam int ENT_W = INST_W + ADDR_W;

  // Handshake: a request/instruction transfers on a rising edge where valid and
  // ready are both high; valid never waits on ready.
  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W-1:0]  pc_count;
  logic              q_full, q_empty, pc_full, pc_empty;
  logic [ENT_W-1:0]  q_head;
  logic [ADDR_W-1:0] rsp_pc;
  logic [SUM_W-1:0]  credit_used;
  logic              accept, rsp_keep, rsp_drop, flush, q_push, q_pop;

  // Everything in flight (kept or to be dropped) consumes a queue credit.
  assign credit_used    = SUM_W'(q_count) + SUM_W'(outstanding) + SUM_W'(discard);
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < SUM_W'(QUEUE_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (discard != '0);
  assign rsp_keep       = imem_rsp_valid && (discard == '0);
  assign flush          = rst || redirect_valid;
  assign q_push         = rsp_keep && !flush;
  assign inst_valid     = !rst && !q_empty;
  assign q_pop          = inst_valid && inst_ready;
  assign {inst_data, inst_pc} = q_head;

  // outstanding counts live requests; discard counts responses owed to a
  // flushed stream and always drains first because memory answers in order.
  always_ff @(posedge clk) begin
    if (flush) begin
      fetch_pc    <= rst ? RESET_PC : redirect_pc;
      outstanding <= '0;
      discard     <= discard + outstanding - CNT_W'(imem_rsp_valid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + ADDR_W'(1);
      outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp_keep);
      discard     <= discard - CNT_W'(rsp_drop);
    end
  end

  risc16_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(QUEUE_DEPTH)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .pop_data  (rsp_pc),
    .full      (pc_full),
    .empty     (pc_empty),
    .count     (pc_count)
  );

  risc16_sync_fifo #(.WIDTH(ENT_W), .DEPTH(QUEUE_DEPTH)) u_inst_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (q_push),
    .push_data ({imem_rsp_data, rsp_pc}),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0 || discard != '0));
  a_pc_track:        assert property (@(posedge clk) disable iff (rst)
    pc_count == outstanding);
  a_pc_avail:        assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> !pc_empty);
  a_pc_room:         assert property (@(posedge clk) disable iff (rst)
    accept |-> !pc_full);
  a_queue_room:      assert property (@(posedge clk) disable iff (rst)
    q_push |-> (!q_full || q_pop));

endmodule

// File: tb/tb_risc16_fetch_unit.sv
// Bench for risc16_fetch_unit: in-order memory model with variable latency and a
// transaction-level reference of the instruction stream decode should see.
module tb_risc16_fetch_unit;

  localparam int          DEPTH       = 4;
  localparam logic [15:0] RESET_PC_TB = 16'h0000;

  typedef struct {
    logic [15:0] addr;
    int          tag;
    int          due_cyc;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready;

  mem_t        mem_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] req_log[$];
  logic [15:0] hs_log[$];
  logic [15:0] exp_pc;
  int          epoch, cyc, base_lat, jitter, first_acc, first_iv;
  int          total, bad, hs_before, exp_hs;
  logic        last_iv;

  risc16_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] inst_of(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One clock cycle: memory drives its response, outputs are checked against the
  // reference at the falling edge, then the reference absorbs the cycle's events.
  task automatic step();
    mem_t cur;
    bit   rsp_now;
    rsp_now = 1'b0;
    cur = '{addr: 16'h0, tag: 0, due_cyc: 0};
    if (mem_q.size() > 0 && mem_q[0].due_cyc <= cyc) begin
      cur = mem_q.pop_front();
      rsp_now = 1'b1;
    end
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? inst_of(cur.addr) : 16'hDEAD;
    @(negedge clk);
    chk("req_valid", imem_req_valid,
        !rst && !redirect_valid && (exp_q.size() + mem_q.size() + int'(rsp_now)) < DEPTH);
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
    chk("inst_valid", inst_valid, !rst && exp_q.size() > 0);
    if (inst_valid && exp_q.size() > 0) chk("inst_head", {inst_pc, inst_data}, exp_q[0]);
    last_iv = inst_valid;
    if (inst_valid && first_iv < 0) first_iv = cyc;
    if (imem_req_valid && imem_req_ready) begin
      int due;
      due = cyc + base_lat + int'($urandom_range(0, jitter));
      if (mem_q.size() > 0 && due <= mem_q[mem_q.size()-1].due_cyc)
        due = mem_q[mem_q.size()-1].due_cyc + 1;
      mem_q.push_back('{addr: exp_pc, tag: epoch, due_cyc: due});
      req_log.push_back(imem_req_addr);
      if (first_acc < 0) first_acc = cyc;
      exp_pc = exp_pc + 16'h1;
    end
    if (inst_valid && inst_ready) begin
      hs_log.push_back(inst_pc);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (rsp_now && cur.tag == epoch) exp_q.push_back({cur.addr, inst_of(cur.addr)});
    if (rst) begin
      exp_q.delete();
      exp_pc = RESET_PC_TB;
      epoch++;
    end else if (redirect_valid) begin
      exp_q.delete();
      exp_pc = redirect_pc;
      epoch++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic clear_logs();
    req_log.delete();
    hs_log.delete();
    first_acc = -1;
    first_iv  = -1;
  endtask

  task automatic run_until_hs(input int max_cycles);
    for (int i = 0; i < max_cycles && hs_log.size() == 0; i++) step();
  endtask

  function automatic logic [31:0] log_at(input int which, input int idx);
    if (which == 0) return (idx < req_log.size()) ? {16'h0, req_log[idx]} : 32'hFFFF_FFFF;
    return (idx < hs_log.size()) ? {16'h0, hs_log[idx]} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    total = 0; bad = 0; epoch = 0; cyc = 0;
    base_lat = 1; jitter = 0; exp_pc = RESET_PC_TB; last_iv = 1'b0;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 16'h0;
    redirect_valid = 1'b0; redirect_pc = 16'h0; inst_ready = 1'b0;
    clear_logs();
    @(posedge clk); #1;

    // streaming with single-cycle memory
    do_reset(2);
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    clear_logs();
    repeat (8) step();
    for (int i = 0; i < 4; i++) chk("t1_req_addr", log_at(0, i), i);
    for (int i = 0; i < 4; i++) chk("t1_inst_pc", log_at(1, i), i);
    chk("t1_latency", first_iv - first_acc, 2);

    // decode stalled: credits cap requests at the queue depth
    do_reset(1);
    inst_ready = 1'b0;
    clear_logs();
    repeat (12) step();
    chk("t2_req_count", req_log.size(), 4);
    inst_ready = 1'b1;
    clear_logs();
    repeat (12) step();
    chk("t2_resume_addr", log_at(0, 0), 4);
    for (int i = 0; i < 6; i++) chk("t2_inst_pc", log_at(1, i), i);

    // redirect with two slow requests in flight
    do_reset(1);
    base_lat = 3;
    for (int i = 0; i < 10 && mem_q.size() < 2; i++) step();
    chk("t3_inflight", mem_q.size(), 2);
    do_redirect(16'h0040);
    clear_logs();
    run_until_hs(30);
    chk("t3_first_pc", log_at(1, 0), 16'h0040);

    // redirect colliding with a handshake and a response
    base_lat = 1;
    repeat (8) step();
    exp_hs = (exp_q.size() > 0) ? 1 : 0;
    hs_before = hs_log.size();
    do_redirect(16'h0100);
    chk("t4_hs_count", hs_log.size() - hs_before, exp_hs);
    step();
    chk("t4_iv_after", last_iv, 1'b0);

    // address wrap
    clear_logs();
    do_redirect(16'hFFFE);
    repeat (6) step();
    chk("t5_addr0", log_at(0, 0), 16'hFFFE);
    chk("t5_addr1", log_at(0, 1), 16'hFFFF);
    chk("t5_addr2", log_at(0, 2), 16'h0000);

    // reset with work queued and requests in flight
    inst_ready = 1'b0;
    base_lat = 3;
    do_reset(1);
    for (int i = 0; i < 20 && !(exp_q.size() == 2 && mem_q.size() == 2); i++) step();
    chk("t6_queued", exp_q.size(), 2);
    chk("t6_inflight", mem_q.size(), 2);
    do_reset(1);
    inst_ready = 1'b1;
    clear_logs();
    run_until_hs(30);
    chk("t6_first_pc", log_at(1, 0), RESET_PC_TB);

    // randomized traffic
    jitter = 3;
    for (int i = 0; i < 1500; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      base_lat       = 1 + int'($urandom_range(0, 2));
      rst            = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_pc    = 16'($urandom);
      step();
    end
    rst = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
